// File: rtl/supervisor_pkg.sv
// Shared constants, field positions and types for the supervisor CSR/trap unit.
package supervisor_pkg;

  localparam logic [11:0] CSR_SSTATUS    = 12'h100;
  localparam logic [11:0] CSR_SIE        = 12'h104;
  localparam logic [11:0] CSR_STVEC      = 12'h105;
  localparam logic [11:0] CSR_SCOUNTEREN = 12'h106;
  localparam logic [11:0] CSR_SSCRATCH   = 12'h140;
  localparam logic [11:0] CSR_SEPC       = 12'h141;
  localparam logic [11:0] CSR_SCAUSE     = 12'h142;
  localparam logic [11:0] CSR_STVAL      = 12'h143;
  localparam logic [11:0] CSR_SIP        = 12'h144;
  localparam logic [11:0] CSR_SATP       = 12'h180;

  localparam logic [3:0] CAUSE_SSI = 4'd1;
  localparam logic [3:0] CAUSE_STI = 4'd5;
  localparam logic [3:0] CAUSE_SEI = 4'd9;

  localparam int SSTATUS_SIE  = 1;
  localparam int SSTATUS_SPIE = 5;
  localparam int SSTATUS_SPP  = 8;
  localparam int SSTATUS_SUM  = 18;
  localparam int SSTATUS_MXR  = 19;
  localparam int SIP_SSIP     = 1;

  localparam logic [63:0] SSTATUS_MASK = 64'h0000_0000_000C_0122;
  localparam logic [63:0] SIE_MASK     = 64'h0000_0000_0000_0222;

  localparam int SATP64_MODE_LSB = 60;
  localparam int SATP64_ASID_LSB = 44;
  localparam int SATP32_MODE_LSB = 31;
  localparam int SATP32_ASID_LSB = 22;

  typedef enum logic [1:0] {
    CSR_OP_READ  = 2'b00,
    CSR_OP_WRITE = 2'b01,
    CSR_OP_SET   = 2'b10,
    CSR_OP_CLEAR = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    PRIV_U    = 2'b00,
    PRIV_S    = 2'b01,
    PRIV_RSVD = 2'b10,
    PRIV_M    = 2'b11
  } priv_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } flush_state_e;

  // MODE and implemented ASID bits: a change in any of these needs a TLB flush.
  function automatic logic [63:0] satp_mode_asid_mask(input int unsigned xlen,
                                                      input int unsigned asid_w);
    logic [63:0] asid_ones;
    asid_ones = (64'd1 << asid_w) - 64'd1;
    if (xlen == 64) return (64'hF << SATP64_MODE_LSB) | (asid_ones << SATP64_ASID_LSB);
    return (64'h1 << SATP32_MODE_LSB) | (asid_ones << SATP32_ASID_LSB);
  endfunction

  function automatic logic [63:0] satp_ppn_mask(input int unsigned xlen);
    if (xlen == 64) return (64'd1 << SATP64_ASID_LSB) - 64'd1;
    return (64'd1 << SATP32_ASID_LSB) - 64'd1;
  endfunction

endpackage

// File: rtl/supervisor_trap_csr_irq_arbiter.sv
// Supervisor interrupt arbiter: enable masking, fixed priority SEI > SSI > STI, registered result.
module s_irq_arbiter
  import supervisor_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] priv_mode,
  input  logic       status_sie,
  input  logic       seip,
  input  logic       ssip,
  input  logic       stip,
  input  logic       seie,
  input  logic       ssie,
  input  logic       stie,
  output logic       irq_req,
  output logic [3:0] irq_cause
);

  logic       global_en;
  logic [2:0] pend;
  logic       irq_req_d, irq_req_q;
  logic [3:0] irq_cause_d, irq_cause_q;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    irq_cause_d = '0;
    global_en   = (priv_mode == PRIV_U) || ((priv_mode == PRIV_S) && status_sie);
    pend        = {seip & seie, ssip & ssie, stip & stie};
    irq_req_d   = global_en && (|pend);
    if (global_en) begin
      if (pend[2])      irq_cause_d = CAUSE_SEI;
      else if (pend[1]) irq_cause_d = CAUSE_SSI;
      else if (pend[0]) irq_cause_d = CAUSE_STI;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      irq_req_q   <= 1'b0;
      irq_cause_q <= '0;
    end else begin
      irq_req_q   <= irq_req_d;
      irq_cause_q <= irq_cause_d;
    end
  end

  assign irq_req   = irq_req_q;
  assign irq_cause = irq_cause_q;

endmodule

// File: rtl/supervisor_trap_csr.sv
// S-mode CSR file with WARL legalisation, trap entry/SRET sequencing and a satp TLB-flush handshake.
module supervisor_trap_csr
  import supervisor_pkg::*;
#(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned ASID_W      = 16,
  parameter bit          VECTORED_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      priv_mode,
  input  logic            csr_valid,
  output logic            csr_ready,
  input  logic [11:0]     csr_addr,
  input  logic [1:0]      csr_op,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_error,
  input  logic            seip_in,
  input  logic            stip_in,
  output logic            irq_req,
  output logic [3:0]      irq_cause,
  input  logic            trap_valid,
  input  logic            trap_is_irq,
  input  logic [3:0]      trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_tval,
  output logic [XLEN-1:0] trap_vector,
  input  logic            sret,
  output logic [XLEN-1:0] sret_pc,
  output logic [1:0]      sret_mode,
  output logic            tlb_flush_req,
  input  logic            tlb_flush_ack,
  output logic [XLEN-1:0] satp,
  output logic            sum,
  output logic            mxr
);

  localparam logic [XLEN-1:0] SSTATUS_WMASK = XLEN'(SSTATUS_MASK);
  localparam logic [XLEN-1:0] SIE_WMASK     = XLEN'(SIE_MASK);
  localparam logic [XLEN-1:0] SATP_MA_MASK  = XLEN'(satp_mode_asid_mask(XLEN, ASID_W));
  localparam logic [XLEN-1:0] SATP_PPN_MASK = XLEN'(satp_ppn_mask(XLEN));
  localparam logic [XLEN-1:0] SCAUSE_MASK   = {1'b1, {(XLEN-5){1'b0}}, 4'hF};

  logic [XLEN-1:0] sstatus_q, sstatus_d, sie_q, sie_d, stvec_q, stvec_d;
  logic [XLEN-1:0] scounteren_q, scounteren_d, sscratch_q, sscratch_d;
  logic [XLEN-1:0] sepc_q, sepc_d, scause_q, scause_d, stval_q, stval_d;
  logic [XLEN-1:0] satp_q, satp_d;
  logic            ssip_q, ssip_d;
  flush_state_e    state_q, state_d;
  logic            flush_req_q, flush_req_d;

  logic            addr_known, is_write, priv_ok, access_ok, is_idle;
  logic            csr_we, satp_mode_legal, satp_ma_change, flush_start;
  logic [XLEN-1:0] sip_rd, csr_rval, csr_wval, satp_new;

  assign sip_rd   = XLEN'({seip_in, 3'b000, stip_in, 3'b000, ssip_q, 1'b0});
  assign is_write = (csr_op != CSR_OP_READ);
  assign priv_ok  = (priv_mode == PRIV_S) || (priv_mode == PRIV_M);
  assign is_idle  = (state_q == ST_IDLE);

  always_comb begin
    addr_known = 1'b1;
    csr_rval   = '0;
    case (csr_addr)
      CSR_SSTATUS:    csr_rval = sstatus_q;
      CSR_SIE:        csr_rval = sie_q;
      CSR_STVEC:      csr_rval = stvec_q;
      CSR_SCOUNTEREN: csr_rval = scounteren_q;
      CSR_SSCRATCH:   csr_rval = sscratch_q;
      CSR_SEPC:       csr_rval = sepc_q;
      CSR_SCAUSE:     csr_rval = scause_q;
      CSR_STVAL:      csr_rval = stval_q;
      CSR_SIP:        csr_rval = sip_rd;
      CSR_SATP:       csr_rval = satp_q;
      default:        addr_known = 1'b0;
    endcase
  end

  always_comb begin
    case (csr_op)
      CSR_OP_WRITE: csr_wval = csr_wdata;
      CSR_OP_SET:   csr_wval = csr_rval | csr_wdata;
      CSR_OP_CLEAR: csr_wval = csr_rval & ~csr_wdata;
      default:      csr_wval = csr_rval;
    endcase
  end

  assign access_ok = csr_valid && priv_ok && addr_known &&
                     !(is_write && (csr_addr[11:10] == 2'b11));
  assign csr_error = csr_valid && !access_ok;
  assign csr_rdata = access_ok ? csr_rval : '0;

  always_comb begin
    satp_new        = csr_wval & (SATP_MA_MASK | SATP_PPN_MASK);
    satp_mode_legal = 1'b1;
    if (XLEN == 64)
      satp_mode_legal = (satp_new[XLEN-1 -: 4] == 4'h0) || (satp_new[XLEN-1 -: 4] == 4'h8);
    satp_ma_change  = (((satp_new ^ satp_q) & SATP_MA_MASK) != '0);
  end

  // A concurrent trap wins over the CSR port; the held access retries later.
  assign csr_we      = access_ok && is_write && is_idle && !trap_valid;
  assign flush_start = csr_we && (csr_addr == CSR_SATP) && satp_mode_legal && satp_ma_change;
  assign csr_ready   = is_idle && !(csr_valid && is_write && trap_valid) && !flush_start;

  always_comb begin
    sstatus_d    = sstatus_q;
    sie_d        = sie_q;
    stvec_d      = stvec_q;
    scounteren_d = scounteren_q;
    sscratch_d   = sscratch_q;
    sepc_d       = sepc_q;
    scause_d     = scause_q;
    stval_d      = stval_q;
    satp_d       = satp_q;
    ssip_d       = ssip_q;
    state_d      = state_q;

    if (csr_we) begin
      case (csr_addr)
        CSR_SSTATUS:    sstatus_d    = csr_wval & SSTATUS_WMASK;
        CSR_SIE:        sie_d        = csr_wval & SIE_WMASK;
        CSR_STVEC:      stvec_d      = {csr_wval[XLEN-1:2], 1'b0,
                                        VECTORED_EN && (csr_wval[1:0] == 2'b01)};
        CSR_SCOUNTEREN: scounteren_d = csr_wval;
        CSR_SSCRATCH:   sscratch_d   = csr_wval;
        CSR_SEPC:       sepc_d       = {csr_wval[XLEN-1:1], 1'b0};
        CSR_SCAUSE:     scause_d     = csr_wval & SCAUSE_MASK;
        CSR_STVAL:      stval_d      = csr_wval;
        CSR_SIP:        ssip_d       = csr_wval[SIP_SSIP];
        CSR_SATP:       if (satp_mode_legal) satp_d = satp_new;
        default: ;
      endcase
    end

    if (sret && !trap_valid && (priv_mode != PRIV_U)) begin
      sstatus_d[SSTATUS_SIE]  = sstatus_q[SSTATUS_SPIE];
      sstatus_d[SSTATUS_SPIE] = 1'b1;
      sstatus_d[SSTATUS_SPP]  = 1'b0;
    end

    if (trap_valid) begin
      sepc_d                  = {trap_pc[XLEN-1:1], 1'b0};
      scause_d                = {trap_is_irq, {(XLEN-5){1'b0}}, trap_cause};
      stval_d                 = trap_is_irq ? '0 : trap_tval;
      sstatus_d[SSTATUS_SPP]  = priv_mode[0];
      sstatus_d[SSTATUS_SPIE] = sstatus_q[SSTATUS_SIE];
      sstatus_d[SSTATUS_SIE]  = 1'b0;
    end

    case (state_q)
      ST_IDLE:  if (flush_start)   state_d = ST_FLUSH;
      ST_FLUSH: if (tlb_flush_ack) state_d = ST_IDLE;
      default:                     state_d = ST_IDLE;
    endcase
    flush_req_d = (state_d == ST_FLUSH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sstatus_q    <= '0;
      sie_q        <= '0;
      stvec_q      <= '0;
      scounteren_q <= '0;
      sscratch_q   <= '0;
      sepc_q       <= '0;
      scause_q     <= '0;
      stval_q      <= '0;
      satp_q       <= '0;
      ssip_q       <= 1'b0;
      state_q      <= ST_IDLE;
      flush_req_q  <= 1'b0;
    end else begin
      sstatus_q    <= sstatus_d;
      sie_q        <= sie_d;
      stvec_q      <= stvec_d;
      scounteren_q <= scounteren_d;
      sscratch_q   <= sscratch_d;
      sepc_q       <= sepc_d;
      scause_q     <= scause_d;
      stval_q      <= stval_d;
      satp_q       <= satp_d;
      ssip_q       <= ssip_d;
      state_q      <= state_d;
      flush_req_q  <= flush_req_d;
    end
  end

  s_irq_arbiter u_irq_arbiter (
    .clk        (clk),
    .rst_n      (rst_n),
    .priv_mode  (priv_mode),
    .status_sie (sstatus_q[SSTATUS_SIE]),
    .seip       (seip_in),
    .ssip       (ssip_q),
    .stip       (stip_in),
    .seie       (sie_q[9]),
    .ssie       (sie_q[1]),
    .stie       (sie_q[5]),
    .irq_req    (irq_req),
    .irq_cause  (irq_cause)
  );

  assign trap_vector   = {stvec_q[XLEN-1:2], 2'b00} +
                         ((stvec_q[0] && trap_is_irq) ? XLEN'({trap_cause, 2'b00}) : '0);
  assign sret_pc       = sepc_q;
  assign sret_mode     = {1'b0, sstatus_q[SSTATUS_SPP]};
  assign tlb_flush_req = flush_req_q;
  assign satp          = satp_q;
  assign sum           = sstatus_q[SSTATUS_SUM];
  assign mxr           = sstatus_q[SSTATUS_MXR];

endmodule

// File: tb/tb_supervisor_trap_csr.sv
// Self-checking bench for supervisor_trap_csr (XLEN=64): vector table, scoreboard and corner sequences.
module tb_supervisor_trap_csr;
  import supervisor_pkg::*;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      priv_mode;
  logic            csr_valid, csr_ready, csr_error;
  logic [11:0]     csr_addr;
  logic [1:0]      csr_op;
  logic [XLEN-1:0] csr_wdata, csr_rdata;
  logic            seip_in, stip_in, irq_req;
  logic [3:0]      irq_cause;
  logic            trap_valid, trap_is_irq;
  logic [3:0]      trap_cause;
  logic [XLEN-1:0] trap_pc, trap_tval, trap_vector;
  logic            sret;
  logic [XLEN-1:0] sret_pc;
  logic [1:0]      sret_mode;
  logic            tlb_flush_req, tlb_flush_ack;
  logic [XLEN-1:0] satp;
  logic            sum, mxr;

  supervisor_trap_csr #(.XLEN(XLEN), .ASID_W(16), .VECTORED_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .priv_mode(priv_mode),
    .csr_valid(csr_valid), .csr_ready(csr_ready), .csr_addr(csr_addr), .csr_op(csr_op),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_error(csr_error),
    .seip_in(seip_in), .stip_in(stip_in), .irq_req(irq_req), .irq_cause(irq_cause),
    .trap_valid(trap_valid), .trap_is_irq(trap_is_irq), .trap_cause(trap_cause),
    .trap_pc(trap_pc), .trap_tval(trap_tval), .trap_vector(trap_vector),
    .sret(sret), .sret_pc(sret_pc), .sret_mode(sret_mode),
    .tlb_flush_req(tlb_flush_req), .tlb_flush_ack(tlb_flush_ack),
    .satp(satp), .sum(sum), .mxr(mxr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [63:0] exp;
  } sb_t;
  sb_t sb_q[$];

  task automatic sb_push(input string name, input logic [63:0] exp);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [63:0] act);
    sb_t e;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      check(e.name, act, e.exp);
    end
  endtask

  typedef struct {
    logic [1:0]  priv;
    logic [1:0]  op;
    logic [11:0] addr;
    logic [63:0] wdata;
    bit          chk_rdata;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(input logic [1:0] p, input logic [1:0] o, input logic [11:0] a,
                              input logic [63:0] w, input bit c, input logic [63:0] r,
                              input logic e);
    vec_t v;
    v.priv = p; v.op = o; v.addr = a; v.wdata = w;
    v.chk_rdata = c; v.exp_rdata = r; v.exp_err = e;
    return v;
  endfunction

  // Advance to just after the next rising edge and drop all one-cycle strobes.
  task automatic step();
    @(posedge clk); #1;
    csr_valid  = 1'b0;
    trap_valid = 1'b0;
    sret       = 1'b0;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [63:0] d);
    step();
    priv_mode = PRIV_S;
    csr_valid = 1'b1; csr_op = CSR_OP_WRITE; csr_addr = a; csr_wdata = d;
    @(negedge clk);
  endtask

  task automatic csr_read_chk(input string name, input logic [11:0] a, input logic [63:0] exp);
    step();
    priv_mode = PRIV_S;
    csr_valid = 1'b1; csr_op = CSR_OP_READ; csr_addr = a; csr_wdata = '0;
    @(negedge clk);
    check(name, csr_rdata, exp);
  endtask

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; priv_mode = PRIV_S;
    csr_valid = 1'b0; csr_addr = '0; csr_op = CSR_OP_READ; csr_wdata = '0;
    seip_in = 1'b0; stip_in = 1'b0;
    trap_valid = 1'b0; trap_is_irq = 1'b0; trap_cause = '0; trap_pc = '0; trap_tval = '0;
    sret = 1'b0; tlb_flush_ack = 1'b0;

    vecs.push_back(mk(PRIV_S, CSR_OP_WRITE, CSR_SSTATUS,  ONES,  0, 0, 0));
    vecs.push_back(mk(PRIV_S, CSR_OP_READ,  CSR_SSTATUS,  0,     1, 64'h00000000000C0122, 0));
    vecs.push_back(mk(PRIV_S, CSR_OP_WRITE, CSR_SIE,      ONES,  0, 0, 0));
    vecs.push_back(mk(PRIV_S, CSR_OP_READ,  CSR_SIE,      0,     1, 64'h222, 0));
    vecs.push_back(mk(PRIV_S, CSR_OP_WRITE, CSR_STVEC,    64'h80000003, 0, 0, 0));
    vecs.push_back(mk(PRIV_S, CSR_OP_READ,  CSR_STVEC,    0,     1, 64'h80000000, 0));
    vecs.push_back(mk(PRIV_S, CSR_OP_WRITE, CSR_STVEC,    64'h80000001, 0, 0, 0));
    vecs.push_back(mk(PRIV_S, CSR_OP_READ,  CSR_STVEC,    0,     1, 64'h80000001, 0));
    vecs.push_back(mk(PRIV_S, CSR_OP_WRITE, CSR_SEPC,     64'h1235, 0, 0, 0));
    vecs.push_back(mk(PRIV_S, CSR_OP_READ,  CSR_SEPC,     0,     1, 64'h1234, 0));
    vecs.push_back(mk(PRIV_S, CSR_OP_WRITE, CSR_SCAUSE,   ONES,  0, 0, 0));
    vecs.push_back(mk(PRIV_S, CSR_OP_READ,  CSR_SCAUSE,   0,     1, 64'h800000000000000F, 0));
    vecs.push_back(mk(PRIV_S, CSR_OP_WRITE, CSR_SIP,      ONES,  0, 0, 0));
    vecs.push_back(mk(PRIV_S, CSR_OP_READ,  CSR_SIP,      0,     1, 64'h2, 0));
    vecs.push_back(mk(PRIV_S, CSR_OP_WRITE, CSR_SSCRATCH, 64'hF0, 0, 0, 0));
    vecs.push_back(mk(PRIV_S, CSR_OP_SET,   CSR_SSCRATCH, 64'h0F, 0, 0, 0));
    vecs.push_back(mk(PRIV_S, CSR_OP_READ,  CSR_SSCRATCH, 0,     1, 64'hFF, 0));
    vecs.push_back(mk(PRIV_S, CSR_OP_CLEAR, CSR_SSCRATCH, 64'hF0, 0, 0, 0));
    vecs.push_back(mk(PRIV_S, CSR_OP_READ,  CSR_SSCRATCH, 0,     1, 64'h0F, 0));
    vecs.push_back(mk(PRIV_U, CSR_OP_READ,  CSR_SSTATUS,  0,     1, 64'h0, 1));
    vecs.push_back(mk(PRIV_U, CSR_OP_WRITE, CSR_SSCRATCH, 64'h99, 0, 0, 1));
    vecs.push_back(mk(PRIV_S, CSR_OP_READ,  CSR_SSCRATCH, 0,     1, 64'h0F, 0));
    vecs.push_back(mk(PRIV_RSVD, CSR_OP_READ, CSR_SSCRATCH, 0,   1, 64'h0, 1));
    vecs.push_back(mk(PRIV_S, CSR_OP_READ,  12'h123,      0,     1, 64'h0, 1));
    vecs.push_back(mk(PRIV_S, CSR_OP_WRITE, 12'hC00,      64'h1, 0, 0, 1));
    vecs.push_back(mk(PRIV_M, CSR_OP_READ,  CSR_SSTATUS,  0,     1, 64'h00000000000C0122, 0));
    vecs.push_back(mk(PRIV_S, CSR_OP_WRITE, CSR_SIP,      64'h0, 0, 0, 0));
    vecs.push_back(mk(PRIV_S, CSR_OP_WRITE, CSR_SIE,      64'h200, 0, 0, 0));
    vecs.push_back(mk(PRIV_S, CSR_OP_READ,  CSR_SIE,      0,     1, 64'h200, 0));
    vecs.push_back(mk(PRIV_S, CSR_OP_WRITE, CSR_STVAL,    64'hABCD, 0, 0, 0));
    vecs.push_back(mk(PRIV_S, CSR_OP_READ,  CSR_STVAL,    0,     1, 64'hABCD, 0));

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", csr_ready, 1);
    check("rst_flush_req", tlb_flush_req, 0);
    check("rst_irq_req", irq_req, 0);
    check("rst_irq_cause", irq_cause, 0);
    check("rst_error", csr_error, 0);
    check("rst_satp", satp, 0);

    // Vector table through the scoreboard
    foreach (vecs[i]) begin
      step();
      priv_mode = vecs[i].priv; csr_valid = 1'b1; csr_op = vecs[i].op;
      csr_addr = vecs[i].addr; csr_wdata = vecs[i].wdata;
      sb_push($sformatf("vec%0d_err", i), 64'(vecs[i].exp_err));
      if (vecs[i].chk_rdata) sb_push($sformatf("vec%0d_rdata", i), vecs[i].exp_rdata);
      sb_push($sformatf("vec%0d_ready", i), 64'd1);
      @(negedge clk);
      sb_pop(64'(csr_error));
      if (vecs[i].chk_rdata) sb_pop(csr_rdata);
      sb_pop(64'(csr_ready));
    end
    check("sb_empty", 64'(sb_q.size()), 0);
    check("sum_out", sum, 1);
    check("mxr_out", mxr, 1);

    // Interrupt latency and priority
    step();
    priv_mode = PRIV_S; seip_in = 1'b1;
    @(negedge clk);
    check("irq_req_latency", irq_req, 0);
    step();
    check("irq_req_sei", irq_req, 1);
    check("irq_cause_sei", irq_cause, 9);
    csr_write(CSR_SIE, 64'h222);
    step();
    stip_in = 1'b1;
    step();
    check("irq_cause_sei_over_sti", irq_cause, 9);
    seip_in = 1'b0;
    step();
    check("irq_cause_sti", irq_cause, 5);
    stip_in = 1'b0;

    // Interrupt trap entry with vectored stvec
    trap_valid = 1'b1; trap_is_irq = 1'b1; trap_cause = 4'd9;
    trap_pc = 64'h1002; trap_tval = 64'hDEAD;
    @(negedge clk);
    check("trap_vector_irq", trap_vector, 64'h80000024);
    csr_read_chk("trap_sepc", CSR_SEPC, 64'h1002);
    csr_read_chk("trap_scause", CSR_SCAUSE, 64'h8000000000000009);
    csr_read_chk("trap_stval_irq", CSR_STVAL, 64'h0);
    csr_read_chk("trap_sstatus", CSR_SSTATUS, 64'h00000000000C0120);

    // Trap beats a concurrent CSR write
    csr_write(CSR_SSTATUS, 64'h00000000000C0122);
    step();
    priv_mode = PRIV_S;
    trap_valid = 1'b1; trap_is_irq = 1'b0; trap_cause = 4'd2;
    trap_pc = 64'h2001; trap_tval = 64'h77;
    csr_valid = 1'b1; csr_op = CSR_OP_WRITE; csr_addr = CSR_SSCRATCH; csr_wdata = 64'h55;
    @(negedge clk);
    check("collide_ready", csr_ready, 0);
    check("trap_vector_exc", trap_vector, 64'h80000000);
    csr_read_chk("collide_sscratch", CSR_SSCRATCH, 64'h0F);
    csr_read_chk("exc_sepc", CSR_SEPC, 64'h2000);
    csr_read_chk("exc_scause", CSR_SCAUSE, 64'h2);
    csr_read_chk("exc_stval", CSR_STVAL, 64'h77);
    csr_read_chk("exc_sstatus", CSR_SSTATUS, 64'h00000000000C0120);

    // SRET
    step();
    priv_mode = PRIV_S; sret = 1'b1;
    @(negedge clk);
    check("sret_pc", sret_pc, 64'h2000);
    check("sret_mode", sret_mode, 2'b01);
    csr_read_chk("sret_sstatus", CSR_SSTATUS, 64'h00000000000C0022);

    // SRET from U-mode is ignored
    csr_write(CSR_SSTATUS, 64'h00000000000C0100);
    step();
    priv_mode = PRIV_U; sret = 1'b1;
    @(negedge clk);
    check("sret_mode_spp1", sret_mode, 2'b01);
    csr_read_chk("sret_u_ignored", CSR_SSTATUS, 64'h00000000000C0100);

    // satp write with MODE change: flush handshake, ack in the third FLUSH cycle
    csr_write(CSR_SATP, 64'h8000000000001234);
    check("satp_w_ready", csr_ready, 0);
    check("satp_w_req", tlb_flush_req, 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (k == 2) tlb_flush_ack = 1'b1;
      @(negedge clk);
      check($sformatf("flush%0d_req", k), tlb_flush_req, 1);
      check($sformatf("flush%0d_ready", k), csr_ready, 0);
    end
    @(posedge clk); #1;
    tlb_flush_ack = 1'b0;
    @(negedge clk);
    check("flush_done_req", tlb_flush_req, 0);
    check("flush_done_ready", csr_ready, 1);
    check("flush_done_satp", satp, 64'h8000000000001234);
    step();
    @(negedge clk);
    check("no_second_flush", tlb_flush_req, 0);

    // Illegal MODE dropped; PPN-only change needs no flush
    csr_write(CSR_SATP, 64'h5000000000001234);
    check("satp_bad_mode_ready", csr_ready, 1);
    step();
    @(negedge clk);
    check("satp_bad_mode_kept", satp, 64'h8000000000001234);
    check("satp_bad_mode_req", tlb_flush_req, 0);
    csr_write(CSR_SATP, 64'h8000000000005678);
    check("satp_ppn_ready", csr_ready, 1);
    step();
    @(negedge clk);
    check("satp_ppn_req", tlb_flush_req, 0);
    csr_read_chk("satp_ppn_read", CSR_SATP, 64'h8000000000005678);

    // Reset while flushing
    csr_write(CSR_SATP, 64'h8001000000005678);
    check("satp_asid_ready", csr_ready, 0);
    step();
    @(negedge clk);
    check("asid_flush_req", tlb_flush_req, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_in_flush_req", tlb_flush_req, 0);
    check("rst_in_flush_satp", satp, 0);
    tlb_flush_ack = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("post_rst_ready", csr_ready, 1);
    check("post_rst_req", tlb_flush_req, 0);
    tlb_flush_ack = 1'b0;
    step();
    @(negedge clk);
    check("post_rst_satp", satp, 0);
    check("post_rst_req2", tlb_flush_req, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
